// File: rtl/infrared_tx.sv
// NEC infrared transmitter: a 32-bit frame written over the slave port is sent LSB first as carrier-modulated marks/spaces.
// Optional NEC repeat-code support is built when IR_REPEAT_EN is defined.
module infrared_tx #(
  parameter int UNIT_CYCLES    = 28125,
  parameter int CARRIER_PERIOD = 1316,
  parameter int CARRIER_HIGH   = 439
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        s_cs_n,
  input  logic        s_address,
  input  logic        s_read,
  output logic [31:0] s_readdata,
  input  logic        s_write,
  input  logic [31:0] s_writedata,
  output logic        irq,
  output logic        ir_out
);

  localparam int CW   = $clog2(16 * UNIT_CYCLES + 1);
  localparam int CARW = $clog2(CARRIER_PERIOD + 1);

  localparam logic [CW-1:0] L1  = CW'(UNIT_CYCLES - 1);
  localparam logic [CW-1:0] L3  = CW'(3 * UNIT_CYCLES - 1);
  localparam logic [CW-1:0] L8  = CW'(8 * UNIT_CYCLES - 1);
  localparam logic [CW-1:0] L16 = CW'(16 * UNIT_CYCLES - 1);
`ifdef IR_REPEAT_EN
  localparam logic [CW-1:0] L4  = CW'(4 * UNIT_CYCLES - 1);
`endif

  typedef enum logic [2:0] {
    IDLE, LEAD_MARK, LEAD_SPACE, BIT_MARK, BIT_SPACE, STOP_MARK
`ifdef IR_REPEAT_EN
    , REP_SPACE
`endif
  } state_t;

  state_t          state, state_next;
  logic [CW-1:0]   unit_cnt, lim;
  logic [CARW-1:0] carrier_cnt;
  logic [4:0]      bit_idx;
  logic [31:0]     frame_reg;
  logic            busy, mark, unit_done, done_frame;
  logic            wr, rd, start_frame, start_rep, rep;

  assign wr          = ~s_cs_n & s_write;
  assign rd          = ~s_cs_n & s_read;
  assign start_frame = wr & ~s_address & (state == IDLE);
`ifdef IR_REPEAT_EN
  assign start_rep   = wr & s_address & s_writedata[0] & (state == IDLE);
`else
  assign start_rep   = 1'b0;
`endif

  // Last counter value of the current state; a 1 bit stretches its space to 3 units.
  always_comb begin
    lim = L1;
    case (state)
      LEAD_MARK:  lim = L16;
      LEAD_SPACE: lim = L8;
      BIT_SPACE:  lim = frame_reg[bit_idx] ? L3 : L1;
`ifdef IR_REPEAT_EN
      REP_SPACE:  lim = L4;
`endif
      default:    lim = L1;
    endcase
  end

  assign unit_done  = (state != IDLE) && (unit_cnt == lim);
  assign done_frame = (state == STOP_MARK) && unit_done;

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:       if (start_frame || start_rep) state_next = LEAD_MARK;
      LEAD_MARK:  if (unit_done) begin
`ifdef IR_REPEAT_EN
                    state_next = rep ? REP_SPACE : LEAD_SPACE;
`else
                    state_next = LEAD_SPACE;
`endif
                  end
      LEAD_SPACE: if (unit_done) state_next = BIT_MARK;
      BIT_MARK:   if (unit_done) state_next = BIT_SPACE;
      BIT_SPACE:  if (unit_done) state_next = (bit_idx == 5'd31) ? STOP_MARK : BIT_MARK;
`ifdef IR_REPEAT_EN
      REP_SPACE:  if (unit_done) state_next = STOP_MARK;
`endif
      STOP_MARK:  if (unit_done) state_next = IDLE;
      default:    state_next = IDLE;
    endcase
  end

  always_comb begin
    busy   = (state != IDLE);
    mark   = (state == LEAD_MARK) || (state == BIT_MARK) || (state == STOP_MARK);
    ir_out = mark && (carrier_cnt < CARW'(CARRIER_HIGH));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      unit_cnt    <= '0;
      carrier_cnt <= '0;
      bit_idx     <= '0;
      frame_reg   <= '0;
      rep         <= 1'b0;
      irq         <= 1'b0;
    end else begin
      unit_cnt <= (state == IDLE || unit_done) ? '0 : unit_cnt + CW'(1);
      // Carrier phase restarts with every state so each mark opens with a high half-cycle.
      if (state_next != state || carrier_cnt == CARW'(CARRIER_PERIOD - 1))
        carrier_cnt <= '0;
      else
        carrier_cnt <= carrier_cnt + CARW'(1);
      if (state == IDLE)
        bit_idx <= '0;
      else if (state == BIT_SPACE && unit_done)
        bit_idx <= bit_idx + 5'd1;
      if (start_frame) begin
        frame_reg <= s_writedata;
        rep       <= 1'b0;
      end else if (start_rep) begin
        rep <= 1'b1;
      end
      if (done_frame) irq <= 1'b1;
      else if (wr)    irq <= 1'b0;
    end
  end

  always_comb begin
    s_readdata = '0;
    if (rd) s_readdata = s_address ? frame_reg : {30'b0, irq, busy};
  end

endmodule
